// File: rtl/uart_rx_deserializer.sv
// Oversampling UART receiver for 11-bit frames (start, 8 data LSB-first, parity, stop) -> {parity, data}.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote of the ticks around the bit centre.
module uart_rx_deserializer #(
  parameter int CLK_FREQ = 1_000_000,
  parameter int SAMPLE   = 16
) (
  input  logic       SysClk,
  input  logic       rst,
  input  logic [1:0] baud_selector,
  input  logic       parity_sel,
  input  logic       rx_serial,
  output logic [8:0] data_out,
  output logic       data_valid,
  output logic       PE,
  output logic       FE,
  output logic       BE,
  output logic       busy
);

  function automatic int calc_div(input int baud);
    int d;
    d = CLK_FREQ / (baud * SAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

  localparam int DIV0 = calc_div(2400);
  localparam int DIV1 = calc_div(9600);
  localparam int DIV2 = calc_div(19200);
  localparam int DIV3 = calc_div(57600);
  localparam int DW   = (DIV0 > 1) ? $clog2(DIV0 + 1) : 1;
  localparam int CW   = $clog2(SAMPLE + 2);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
  } state_t;

  state_t          state_reg;
  logic [1:0]      sync_reg;
  logic            rxs_prev_reg;
  logic [DW-1:0]   div_cnt_reg;
  logic [CW-1:0]   smp_cnt_reg;
  logic [2:0]      bit_cnt_reg;
  logic [7:0]      shift_reg;
  logic            par_reg;
  logic [1:0]      baud_reg;
  logic            psel_reg;
`ifdef UART_RX_MAJORITY_EN
  logic [1:0]      smp_hist_reg;
`else
  logic            smp_hist_reg;
`endif

  logic            rxs;
  logic [1:0]      baud_eff;
  logic [DW-1:0]   div_cur;
  logic            tick;
  logic            decide;
  logic            bit_val;

  assign rxs = sync_reg[1];

  // The divider follows the live selector while idle and the latched one inside a frame.
  always_comb begin
    baud_eff = (state_reg == IDLE) ? baud_selector : baud_reg;
    case (baud_eff)
      2'd0:    div_cur = DW'(DIV0);
      2'd1:    div_cur = DW'(DIV1);
      2'd2:    div_cur = DW'(DIV2);
      default: div_cur = DW'(DIV3);
    endcase
    tick = (div_cnt_reg >= div_cur - 1'b1);
  end

  // smp_cnt_reg reaches SAMPLE on the centre tick; the bit is resolved one tick later,
  // so both sampling modes keep the same frame timing.
  assign decide = tick && (smp_cnt_reg == CW'(SAMPLE));

`ifdef UART_RX_MAJORITY_EN
  assign bit_val = (smp_hist_reg[1] & smp_hist_reg[0]) |
                   (smp_hist_reg[1] & rxs) |
                   (smp_hist_reg[0] & rxs);
`else
  assign bit_val = smp_hist_reg;
`endif

  always_ff @(posedge SysClk) begin
    if (rst) begin
      state_reg    <= IDLE;
      sync_reg     <= 2'b11;
      rxs_prev_reg <= 1'b1;
      div_cnt_reg  <= '0;
      smp_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      par_reg      <= 1'b0;
      baud_reg     <= '0;
      psel_reg     <= 1'b0;
      smp_hist_reg <= '1;
      data_out     <= '0;
      data_valid   <= 1'b0;
      PE           <= 1'b0;
      FE           <= 1'b0;
      BE           <= 1'b0;
      busy         <= 1'b0;
    end else begin
      sync_reg     <= {sync_reg[0], rx_serial};
      rxs_prev_reg <= rxs;
      data_valid   <= 1'b0;
      div_cnt_reg  <= tick ? '0 : div_cnt_reg + 1'b1;
      if (tick) begin
        smp_cnt_reg <= smp_cnt_reg + 1'b1;
`ifdef UART_RX_MAJORITY_EN
        smp_hist_reg <= {smp_hist_reg[0], rxs};
`else
        smp_hist_reg <= rxs;
`endif
      end

      case (state_reg)
        IDLE: begin
          if (rxs_prev_reg && !rxs) begin
            state_reg   <= START;
            div_cnt_reg <= '0;
            smp_cnt_reg <= CW'(SAMPLE / 2);
            baud_reg    <= baud_selector;
            psel_reg    <= parity_sel;
            busy        <= 1'b1;
          end
        end
        START: begin
          if (decide) begin
            smp_cnt_reg <= CW'(1);
            bit_cnt_reg <= '0;
            if (bit_val) begin
              state_reg <= IDLE;
              busy      <= 1'b0;
            end else begin
              state_reg <= DATA;
            end
          end
        end
        DATA: begin
          if (decide) begin
            smp_cnt_reg <= CW'(1);
            shift_reg   <= {bit_val, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == 3'd7) state_reg <= PARITY;
          end
        end
        PARITY: begin
          if (decide) begin
            smp_cnt_reg <= CW'(1);
            par_reg     <= bit_val;
            state_reg   <= STOP;
          end
        end
        STOP: begin
          if (decide) begin
            smp_cnt_reg <= CW'(1);
            data_valid  <= 1'b1;
            data_out    <= {par_reg, shift_reg};
            PE          <= (^{shift_reg, par_reg}) ^ psel_reg;
            FE          <= ~bit_val;
            BE          <= ~bit_val & (shift_reg == 8'h00) & ~par_reg;
            if (bit_val) begin
              state_reg <= IDLE;
              busy      <= 1'b0;
            end else begin
              state_reg <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          // A held break must not re-trigger: wait for the line to return high first.
          if (rxs) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: directed scenarios plus randomized frames
// compared against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] baud_selector = 2'd1;
  logic       parity_sel = 1'b0;
  logic       rx_serial = 1'b1;
  logic [8:0] data_out;
  logic       data_valid;
  logic       PE;
  logic       FE;
  logic       BE;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx_deserializer dut (
    .SysClk        (clk),
    .rst           (rst),
    .baud_selector (baud_selector),
    .parity_sel    (parity_sel),
    .rx_serial     (rx_serial),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .PE            (PE),
    .FE            (FE),
    .BE            (BE),
    .busy          (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Frame-level model: returns {parity bit, data, PE, FE, BE}.
  function automatic logic [11:0] model(input logic [7:0] d, input logic p,
                                        input logic stop, input logic psel);
    int   ones;
    logic pe, fe, be;
    ones = $countones(d) + int'(p);
    pe   = psel ? (ones % 2 == 0) : (ones % 2 == 1);
    fe   = (stop == 1'b0);
    be   = fe && (d == 8'h00) && (p == 1'b0);
    return {p, d, pe, fe, be};
  endfunction

  function automatic int bitlen_of(input logic [1:0] sel);
    int tbl [4] = '{416, 96, 48, 16};
    return tbl[sel];
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  logic [11:0] rx_q [$];
  int   cyc = 0;
  int   pulses = 0;
  int   wide_pulses = 0;
  int   dv_cyc = 0;
  int   busy_rise_cyc = 0;
  int   fall_cyc = 0;
  logic dv_prev = 1'b0;
  logic busy_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid) begin
      rx_q.push_back({data_out, PE, FE, BE});
      pulses++;
      dv_cyc = cyc;
    end
    if (data_valid && dv_prev) wide_pulses++;
    if (busy && !busy_prev) busy_rise_cyc = cyc;
    dv_prev   = data_valid;
    busy_prev = busy;
  end

  task automatic drive_bit(input logic v, input int bl);
    rx_serial = v;
    repeat (bl) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop,
                            input int bl, input bit scramble);
    fall_cyc = cyc;
    drive_bit(1'b0, bl);
    // Mid-frame selector changes must be ignored by the receiver.
    if (scramble) begin
      baud_selector = 2'($urandom_range(0, 3));
      parity_sel    = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 8; i++) drive_bit(d[i], bl);
    drive_bit(p, bl);
    drive_bit(stop, bl);
    rx_serial = 1'b1;
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d, input logic p,
                              input logic stop, input logic psel);
    int          waited;
    logic [11:0] got, exp;
    waited = 0;
    exp    = model(d, p, stop, psel);
    while (rx_q.size() == 0 && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    if (rx_q.size() == 0) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      got = rx_q.pop_front();
      $display("frame %s: data=%02h p=%0b stop=%0b psel=%0b -> out=%03h PE=%0b FE=%0b BE=%0b (model %03h %0b%0b%0b)",
               tag, d, p, stop, psel, got[11:3], got[2], got[1], got[0],
               exp[11:3], exp[2], exp[1], exp[0]);
      check(tag, 32'(got), 32'(exp));
    end
  endtask

  initial begin
    logic [11:0] last_exp;
    int          lat_diff;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_data_out", 32'(data_out), 32'd0);
    check("reset_valid", 32'(data_valid), 32'd0);
    check("reset_flags", 32'({PE, FE, BE}), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);

    // 0x55 even parity, busy rise and end-to-end latency
    baud_selector = 2'd1;
    parity_sel    = 1'b0;
    send_frame(8'h55, 1'b0, 1'b1, 96, 1'b0);
    expect_frame("x55", 8'h55, 1'b0, 1'b1, 1'b0);
    check("busy_rise_delay", 32'(busy_rise_cyc - fall_cyc), 32'd3);
    lat_diff = (dv_cyc - fall_cyc) - (3 + 6 * (8 + 160) + 1);
    check("latency_within_tick", 32'(lat_diff >= -6 && lat_diff <= 6), 32'd1);
    @(negedge clk);
    check("busy_after_x55", 32'(busy), 32'd0);

    // Back-to-back frames
    send_frame(8'hE5, 1'b1, 1'b1, 96, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b1, 96, 1'b0);
    expect_frame("xE5", 8'hE5, 1'b1, 1'b1, 1'b0);
    expect_frame("xFF", 8'hFF, 1'b1, 1'b1, 1'b0);
    last_exp = model(8'hFF, 1'b1, 1'b1, 1'b0);
    repeat (100) @(negedge clk);

    // Glitch shorter than half a bit
    rx_serial = 1'b0;
    repeat (40) @(negedge clk);
    rx_serial = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch_no_pulse", 32'(rx_q.size()), 32'd0);
    check("glitch_busy", 32'(busy), 32'd0);
    check("glitch_outputs_held", 32'({data_out, PE, FE, BE}), 32'(last_exp));

    // Break: line held low for 20 bit times
    rx_serial = 1'b0;
    repeat (20 * 96) @(negedge clk);
    check("break_single_pulse", 32'(rx_q.size()), 32'd1);
    expect_frame("break", 8'h00, 1'b0, 1'b0, 1'b0);
    check("break_busy_held", 32'(busy), 32'd1);
    rx_serial = 1'b1;
    repeat (2 * 96) @(negedge clk);
    check("break_no_repeat", 32'(rx_q.size()), 32'd0);
    check("break_busy_release", 32'(busy), 32'd0);
    send_frame(8'h3C, 1'b0, 1'b1, 96, 1'b0);
    expect_frame("x3C", 8'h3C, 1'b0, 1'b1, 1'b0);
    repeat (100) @(negedge clk);

    // Reset during the 4th data bit of 0xA7
    fall_cyc = cyc;
    drive_bit(1'b0, 96);
    drive_bit(1'b1, 96);
    drive_bit(1'b1, 96);
    drive_bit(1'b1, 96);
    rx_serial = 1'b0;
    repeat (48) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx_serial = 1'b1;
    repeat (2000) @(negedge clk);
    check("rst_no_pulse", 32'(rx_q.size()), 32'd0);
    check("rst_outputs_zero", 32'({data_out, PE, FE, BE, data_valid}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    send_frame(8'hA7, 1'b1, 1'b1, 96, 1'b0);
    expect_frame("xA7", 8'hA7, 1'b1, 1'b1, 1'b0);
    repeat (100) @(negedge clk);

    // Baud sweep
    for (int s = 0; s < 4; s++) begin
      baud_selector = 2'(s);
      parity_sel    = 1'b0;
      repeat (50) @(negedge clk);
      send_frame(8'h96, 1'b0, 1'b1, bitlen_of(2'(s)), 1'b0);
      expect_frame($sformatf("sweep%0d", s), 8'h96, 1'b0, 1'b1, 1'b0);
      repeat (2 * bitlen_of(2'(s))) @(negedge clk);
    end

    // Randomized frames
    for (int n = 0; n < 30; n++) begin
      logic [1:0] sel;
      logic       psel, p, stop;
      logic [7:0] d;
      int         bl, gap;
      sel  = 2'($urandom_range(1, 3));
      psel = 1'($urandom_range(0, 1));
      d    = 8'($urandom_range(0, 255));
      p    = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 99) < 85);
      bl   = bitlen_of(sel);
      baud_selector = sel;
      parity_sel    = psel;
      send_frame(d, p, stop, bl, 1'($urandom_range(0, 1)));
      expect_frame($sformatf("rand%0d", n), d, p, stop, psel);
      gap = stop ? $urandom_range(0, 2) * bl : bl + $urandom_range(0, bl);
      repeat (gap) @(negedge clk);
    end

    repeat (200) @(negedge clk);
    check("no_extra_pulses", 32'(rx_q.size()), 32'd0);
    check("pulse_width", 32'(wide_pulses), 32'd0);
    check("pulse_total", 32'(pulses), 32'd40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
